// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the pipeline's data-memory path to the
// 16-bit external SRAM.
package arm_mem_pkg;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;
  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_DATA_W       = 16;
  localparam int          CNT_W             = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Word index inside the SRAM window; the offset wraps modulo 2^32 and the byte lane is dropped.
  function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [31:0] addr,
                                                        input logic [31:0] base);
    return (SRAM_ADDR_W-1)'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: cleared on phase entry, flags the final wait cycle.
module sram_wait_counter
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Phase cycle count; load takes priority over advancing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= 4'd0;
    end else if (en) begin
      count_r <= count_r + 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == LAST_VAL);

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline load/store into two timed 16-bit SRAM accesses
// and stalls the pipeline through ready until the pair has completed.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int          WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  mem_state_e             state_r;
  mem_state_e             state_nxt_s;
  logic                   req_s;
  logic                   load_s;
  logic                   en_s;
  logic                   last_s;
  logic                   op_wr_r;
  logic [SRAM_DATA_W-1:0] wdata_hi_r;
  logic [SRAM_ADDR_W-2:0] word_r;
  logic [SRAM_ADDR_W-2:0] word_s;

  assign req_s  = wr_en | rd_en;
  assign word_s = word_index(address, ADDR_BASE);
  assign ready  = (state_r == DONE) | ((state_r == IDLE) & ~req_s);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .en   (en_s),
    .last (last_s)
  );

  // Next-state and counter control; every phase change restarts the counter.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    en_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_nxt_s = LOW;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOW: begin
        if (last_s) begin
          state_nxt_s = HIGH;
          load_s      = 1'b1;
        end else begin
          en_s = 1'b1;
        end
      end
      HIGH: begin
        if (last_s) begin
          state_nxt_s = DONE;
          load_s      = 1'b1;
        end else begin
          en_s = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and request latch; the latched copy is all later phases use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      op_wr_r    <= 1'b0;
      wdata_hi_r <= 16'h0000;
      word_r     <= 17'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && req_s) begin
        op_wr_r    <= wr_en;
        wdata_hi_r <= write_data[31:16];
        word_r     <= word_s;
      end
    end
  end

  // SRAM pins are registered one phase ahead so each half sees stable address and strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'h0000;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      read_data   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            sram_addr   <= {word_s, 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end else begin
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end
        end
        LOW: begin
          if (last_s) begin
            sram_addr   <= {word_r, 1'b1};
            sram_dq_out <= wdata_hi_r;
            if (!op_wr_r) begin
              read_data[15:0] <= sram_dq_in;
            end
          end
        end
        HIGH: begin
          if (last_s) begin
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!op_wr_r) begin
              read_data[31:16] <= sram_dq_in;
            end
          end
        end
        DONE: begin
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
        end
        default: begin
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller against a behavioural 16-bit SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;

  logic [15:0] mem [0:262143];
  logic [17:0] cyc_addr [0:39];
  logic [15:0] cyc_dout [0:39];
  logic        cyc_wen  [0:39];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] lo;
    logic [17:0] hi;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs [0:7];

  sram_controller #(
    .ADDR_BASE   (32'd1024),
    .WAIT_CYCLES (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr] <= sram_dq_out;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a clock edge; returns at the start of the cycle after DONE.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, output int stall,
                            output logic [31:0] rdata_done);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    stall = 0;
    rdata_done = 32'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cyc_addr[c] = sram_addr;
      cyc_dout[c] = sram_dq_out;
      cyc_wen[c]  = sram_we_n;
      if (ready) begin
        rdata_done = read_data;
        break;
      end
      stall++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int          stall;
    int          we_before;
    int          wlow;
    logic [31:0] rd_val;

    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;

    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'h00000, 18'h00001, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 18'h00000, 18'h00001, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1032, 32'h12345678, 18'h00004, 18'h00005, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1032, 32'h00000000, 18'h00004, 18'h00005, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'd1000, 32'hCAFEF00D, 18'h3FFF4, 18'h3FFF5, 32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'd1000, 32'h00000000, 18'h3FFF4, 18'h3FFF5, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 18'h00002, 18'h00003, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 18'h00002, 18'h00003, 32'hA5A55A5A};

    #2 rst = 1'b0;
    #10;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("reset_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("reset_read_data", read_data, 32'h0);
    chk("reset_addr", {14'd0, sram_addr}, 32'd0);
    chk("reset_dq_out", {16'd0, sram_dq_out}, 32'd0);

    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Rows run back to back: each request appears in the cycle after the previous DONE.
    for (int i = 0; i < 8; i++) begin
      we_before = we_cnt;
      run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, stall, rd_val);
      chk($sformatf("v%0d_stall", i), stall, 32'd11);
      chk($sformatf("v%0d_addr_lo", i), {14'd0, cyc_addr[1]}, {14'd0, vecs[i].lo});
      chk($sformatf("v%0d_addr_lo_end", i), {14'd0, cyc_addr[5]}, {14'd0, vecs[i].lo});
      chk($sformatf("v%0d_addr_hi", i), {14'd0, cyc_addr[6]}, {14'd0, vecs[i].hi});
      chk($sformatf("v%0d_addr_hi_end", i), {14'd0, cyc_addr[10]}, {14'd0, vecs[i].hi});
      chk($sformatf("v%0d_read_data", i), rd_val, vecs[i].rdata);
      wlow = 0;
      for (int c = 1; c <= 10; c++) if (cyc_wen[c] == 1'b0) wlow++;
      chk($sformatf("v%0d_we_low_cycles", i), wlow, vecs[i].wr ? 32'd10 : 32'd0);
      chk($sformatf("v%0d_strobe_edges", i), we_cnt - we_before, vecs[i].wr ? 32'd10 : 32'd0);
      chk($sformatf("v%0d_we_idle", i), {31'd0, cyc_wen[0]}, 32'd1);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_dq_lo", i), {16'd0, cyc_dout[1]}, {16'd0, vecs[i].wdata[15:0]});
        chk($sformatf("v%0d_dq_hi", i), {16'd0, cyc_dout[6]}, {16'd0, vecs[i].wdata[31:16]});
        chk($sformatf("v%0d_mem_lo", i), {16'd0, mem[vecs[i].lo]}, {16'd0, vecs[i].wdata[15:0]});
        chk($sformatf("v%0d_mem_hi", i), {16'd0, mem[vecs[i].hi]}, {16'd0, vecs[i].wdata[31:16]});
      end
    end

    // Reset in the middle of the high half of a write, request held throughout.
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
    for (int c = 0; c < 7; c++) @(posedge clk);
    @(negedge clk);
    chk("midrst_pre_we_n", {31'd0, sram_we_n}, 32'd0);
    chk("midrst_pre_addr", {14'd0, sram_addr}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("midrst_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("midrst_addr", {14'd0, sram_addr}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_read_data", read_data, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_addr", {14'd0, sram_addr}, 32'd0);
    chk("restart_we_n", {31'd0, sram_we_n}, 32'd0);
    chk("restart_dq", {16'd0, sram_dq_out}, 32'h2222);
    stall = 1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) break;
      stall++;
    end
    chk("restart_stall", stall, 32'd10);
    @(posedge clk); #1;
    wr_en = 1'b0;
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, stall, rd_val);
    chk("restart_readback", rd_val, 32'h11112222);
    chk("restart_read_stall", stall, 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
